cond_flag_unit: RTL and testbench

//   Consumer end of the ALU flag interface {N,Z,C,V}. Holds the architectural flag register.

---
 rtl/cond_flag_if.sv | 31 +++
 rtl/cond_flag_unit.sv | 128 ++++++++++++
 tb/tb_cond_flag_unit.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/cond_flag_if.sv
// Handshake bundle between decode/ALU (master) and the condition/flag unit (slave).
interface cond_flag_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_cond;
  logic [1:0] in_flagw;
  logic [3:0] in_alu_flags;
  logic       in_pcs;
  logic       in_regw;
  logic       in_memw;
  logic       in_nowrite;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic       out_condex;
  logic       out_pcsrc;
  logic       out_regwrite;
  logic       out_memwrite;

  modport master (
    output in_valid, in_cond, in_flagw, in_alu_flags, in_pcs, in_regw, in_memw,
           in_nowrite, flush, out_ready,
    input  in_ready, out_valid, out_condex, out_pcsrc, out_regwrite, out_memwrite
  );

  modport slave (
    input  in_valid, in_cond, in_flagw, in_alu_flags, in_pcs, in_regw, in_memw,
           in_nowrite, flush, out_ready,
    output in_ready, out_valid, out_condex, out_pcsrc, out_regwrite, out_memwrite
  );
endinterface

// File: rtl/cond_flag_unit.sv
// Architectural {N,Z,C,V} register, condition evaluation and condition-gated controls
// behind a one-entry valid/ready output stage, with saturating exec/skip statistics.
module cond_flag_unit #(
  parameter logic [3:0] FLAG_RESET  = 4'b0000,
  parameter bit         COND_F_EXEC = 1'b1,
  parameter int         CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  cond_flag_if.slave       bus,
  output logic [3:0]       flags,
  output logic [CNT_W-1:0] exec_cnt,
  output logic [CNT_W-1:0] skip_cnt
);

  // Condition field evaluated against the committed flags {N,Z,C,V}.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, r;
    {n, z, c, v} = f;
    case (cond)
      4'h0: r = z;
      4'h1: r = ~z;
      4'h2: r = c;
      4'h3: r = ~c;
      4'h4: r = n;
      4'h5: r = ~n;
      4'h6: r = v;
      4'h7: r = ~v;
      4'h8: r = c & ~z;
      4'h9: r = ~c | z;
      4'hA: r = (n == v);
      4'hB: r = (n != v);
      4'hC: r = ~z & (n == v);
      4'hD: r = z | (n != v);
      4'hE: r = 1'b1;
      4'hF: r = COND_F_EXEC;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [3:0]       flags_q, flags_d;
  logic             out_valid_q, out_valid_d;
  logic             condex_q, condex_d;
  logic             pcsrc_q, pcsrc_d;
  logic             regwrite_q, regwrite_d;
  logic             memwrite_q, memwrite_d;
  logic [CNT_W-1:0] exec_q, exec_d;
  logic [CNT_W-1:0] skip_q, skip_d;
  logic             in_ready_s, accept_s, condex_s;

  // Handshake and condition decode for the presented instruction.
  always_comb begin
    in_ready_s = ~out_valid_q | bus.out_ready;
    accept_s   = bus.in_valid & in_ready_s & ~bus.flush;
    condex_s   = cond_pass(bus.in_cond, flags_q);
  end

  // Next-state: flag commit, output capture and counters on accept.
  always_comb begin
    flags_d    = flags_q;
    condex_d   = condex_q;
    pcsrc_d    = pcsrc_q;
    regwrite_d = regwrite_q;
    memwrite_d = memwrite_q;
    exec_d     = exec_q;
    skip_d     = skip_q;
    if (accept_s) begin
      condex_d   = condex_s;
      pcsrc_d    = bus.in_pcs & condex_s;
      regwrite_d = bus.in_regw & condex_s & ~bus.in_nowrite;
      memwrite_d = bus.in_memw & condex_s;
      if (condex_s) begin
        if (bus.in_flagw[1]) flags_d[3:2] = bus.in_alu_flags[3:2];
        else                 flags_d[3:2] = flags_q[3:2];
        if (bus.in_flagw[0]) flags_d[1:0] = bus.in_alu_flags[1:0];
        else                 flags_d[1:0] = flags_q[1:0];
        exec_d = (exec_q == CNT_MAX) ? exec_q : exec_q + CNT_ONE;
      end else begin
        skip_d = (skip_q == CNT_MAX) ? skip_q : skip_q + CNT_ONE;
      end
    end else begin
      flags_d = flags_q;
    end
    // A flush drops the pending entry even if downstream is stalled.
    if (bus.flush)          out_valid_d = 1'b0;
    else if (accept_s)      out_valid_d = 1'b1;
    else if (bus.out_ready) out_valid_d = 1'b0;
    else                    out_valid_d = out_valid_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q     <= FLAG_RESET;
      out_valid_q <= 1'b0;
      condex_q    <= 1'b0;
      pcsrc_q     <= 1'b0;
      regwrite_q  <= 1'b0;
      memwrite_q  <= 1'b0;
      exec_q      <= {CNT_W{1'b0}};
      skip_q      <= {CNT_W{1'b0}};
    end else begin
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
      condex_q    <= condex_d;
      pcsrc_q     <= pcsrc_d;
      regwrite_q  <= regwrite_d;
      memwrite_q  <= memwrite_d;
      exec_q      <= exec_d;
      skip_q      <= skip_d;
    end
  end

  assign bus.in_ready     = in_ready_s;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_condex   = condex_q;
  assign bus.out_pcsrc    = pcsrc_q;
  assign bus.out_regwrite = regwrite_q;
  assign bus.out_memwrite = memwrite_q;
  assign flags            = flags_q;
  assign exec_cnt         = exec_q;
  assign skip_cnt         = skip_q;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Bench: two DUT configurations share one stimulus stream; a behavioural model checks
// every cycle, and directed scenarios pin literal values.
module tb_cond_flag_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, in_valid, flush, out_ready, in_pcs, in_regw, in_memw, in_nowrite;
  logic [3:0] in_cond, in_alu;
  logic [1:0] in_flagw;
  logic [3:0] flags_a, flags_b;
  logic [15:0] exec_a, skip_a;
  logic [3:0]  exec_b, skip_b;
  int checks = 0;
  int errors = 0;

  cond_flag_if ia ();
  cond_flag_if ib ();
  assign ia.in_valid = in_valid;     assign ib.in_valid = in_valid;
  assign ia.in_cond = in_cond;       assign ib.in_cond = in_cond;
  assign ia.in_flagw = in_flagw;     assign ib.in_flagw = in_flagw;
  assign ia.in_alu_flags = in_alu;   assign ib.in_alu_flags = in_alu;
  assign ia.in_pcs = in_pcs;         assign ib.in_pcs = in_pcs;
  assign ia.in_regw = in_regw;       assign ib.in_regw = in_regw;
  assign ia.in_memw = in_memw;       assign ib.in_memw = in_memw;
  assign ia.in_nowrite = in_nowrite; assign ib.in_nowrite = in_nowrite;
  assign ia.flush = flush;           assign ib.flush = flush;
  assign ia.out_ready = out_ready;   assign ib.out_ready = out_ready;

  cond_flag_unit #(.FLAG_RESET(4'b0000), .COND_F_EXEC(1'b1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .bus(ia), .flags(flags_a), .exec_cnt(exec_a), .skip_cnt(skip_a));
  cond_flag_unit #(.FLAG_RESET(4'b0000), .COND_F_EXEC(1'b0), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .bus(ib), .flags(flags_b), .exec_cnt(exec_b), .skip_cnt(skip_b));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Conditions come in complementary pairs: odd code = negation of the even one.
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f, input bit fx);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (c == 4'hF) return fx;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  // Reference model state, index 0 = dut_a, 1 = dut_b
  bit         m_on = 1'b0;
  bit         m_ov;
  logic [3:0] m_flags [2];
  int         m_exec [2], m_skip [2];
  bit         m_cx [2], m_pc [2], m_rw [2], m_mw [2];

  always @(posedge clk) begin
    bit rdy, acc, ex;
    int maxc;
    if (reset) begin
      m_on = 1'b1; m_ov = 1'b0;
      for (int k = 0; k < 2; k++) begin
        m_flags[k] = 4'b0000; m_exec[k] = 0; m_skip[k] = 0;
        m_cx[k] = 0; m_pc[k] = 0; m_rw[k] = 0; m_mw[k] = 0;
      end
    end else if (m_on) begin
      rdy = !m_ov || out_ready;
      acc = in_valid && rdy && !flush;
      if (acc) begin
        for (int k = 0; k < 2; k++) begin
          maxc = (k == 0) ? 65535 : 15;
          ex = cond_ok(in_cond, m_flags[k], k == 0);
          m_cx[k] = ex;
          m_pc[k] = in_pcs && ex;
          m_rw[k] = in_regw && ex && !in_nowrite;
          m_mw[k] = in_memw && ex;
          if (ex) begin
            if (in_flagw[1]) m_flags[k][3:2] = in_alu[3:2];
            if (in_flagw[0]) m_flags[k][1:0] = in_alu[1:0];
            if (m_exec[k] < maxc) m_exec[k]++;
          end else if (m_skip[k] < maxc) m_skip[k]++;
        end
      end
      m_ov = flush ? 1'b0 : (acc ? 1'b1 : (out_ready ? 1'b0 : m_ov));
    end
  end

  // Compare process, mid-cycle.
  always @(negedge clk) begin
    if (m_on) begin
      chk("in_ready_a", 32'(ia.in_ready), 32'(!m_ov || out_ready));
      chk("in_ready_b", 32'(ib.in_ready), 32'(!m_ov || out_ready));
      chk("out_valid_a", 32'(ia.out_valid), 32'(m_ov));
      chk("out_valid_b", 32'(ib.out_valid), 32'(m_ov));
      chk("condex_a", 32'(ia.out_condex), 32'(m_cx[0]));
      chk("condex_b", 32'(ib.out_condex), 32'(m_cx[1]));
      chk("pcsrc_a", 32'(ia.out_pcsrc), 32'(m_pc[0]));
      chk("pcsrc_b", 32'(ib.out_pcsrc), 32'(m_pc[1]));
      chk("regwrite_a", 32'(ia.out_regwrite), 32'(m_rw[0]));
      chk("regwrite_b", 32'(ib.out_regwrite), 32'(m_rw[1]));
      chk("memwrite_a", 32'(ia.out_memwrite), 32'(m_mw[0]));
      chk("memwrite_b", 32'(ib.out_memwrite), 32'(m_mw[1]));
      chk("flags_a", 32'(flags_a), 32'(m_flags[0]));
      chk("flags_b", 32'(flags_b), 32'(m_flags[1]));
      chk("exec_a", 32'(exec_a), 32'(m_exec[0]));
      chk("exec_b", 32'(exec_b), 32'(m_exec[1]));
      chk("skip_a", 32'(skip_a), 32'(m_skip[0]));
      chk("skip_b", 32'(skip_b), 32'(m_skip[1]));
    end
  end

  task automatic send(input logic [3:0] c, input logic [1:0] fw, input logic [3:0] alu,
                      input logic pcs, input logic regw, input logic memw);
    in_valid = 1'b1; in_cond = c; in_flagw = fw; in_alu = alu;
    in_pcs = pcs; in_regw = regw; in_memw = memw; in_nowrite = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_cond = 4'h0; in_flagw = 2'b00; in_alu = 4'h0;
    in_pcs = 1'b0; in_regw = 1'b0; in_memw = 1'b0; in_nowrite = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_flags", 32'(flags_a), 32'h0);
    chk("rst_valid", 32'(ia.out_valid), 32'h0);
    chk("rst_exec", 32'(exec_a), 32'h0);
    chk("rst_regwrite", 32'(ia.out_regwrite), 32'h0);

    // 1: unconditional op sets Z
    send(4'hE, 2'b11, 4'b0100, 1'b0, 1'b1, 1'b0);
    chk("t1_valid", 32'(ia.out_valid), 32'h1);
    chk("t1_regwrite", 32'(ia.out_regwrite), 32'h1);
    chk("t1_flags", 32'(flags_a), 32'h4);
    chk("t1_exec", 32'(exec_a), 32'h1);

    // 2: NE with Z=1 is skipped and commits nothing
    send(4'h1, 2'b11, 4'b1000, 1'b0, 1'b1, 1'b0);
    chk("t2_condex", 32'(ia.out_condex), 32'h0);
    chk("t2_regwrite", 32'(ia.out_regwrite), 32'h0);
    chk("t2_flags", 32'(flags_a), 32'h4);
    chk("t2_skip", 32'(skip_a), 32'h1);

    // 3: HI right after the op that set C sees the new flags
    send(4'hE, 2'b11, 4'b0010, 1'b0, 1'b0, 1'b0);
    send(4'h8, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0);
    chk("t3_pcsrc", 32'(ia.out_pcsrc), 32'h1);
    chk("t3_flags", 32'(flags_a), 32'h2);

    // 4: downstream stall holds the output and blocks the next op
    out_ready = 1'b0;
    in_valid = 1'b1; in_cond = 4'hE; in_flagw = 2'b11; in_alu = 4'b1111;
    in_pcs = 1'b0; in_regw = 1'b0; in_memw = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("t4_in_ready", 32'(ia.in_ready), 32'h0);
      chk("t4_hold_pcsrc", 32'(ia.out_pcsrc), 32'h1);
      chk("t4_hold_valid", 32'(ia.out_valid), 32'h1);
      chk("t4_flags", 32'(flags_a), 32'h2);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t4_flags_after", 32'(flags_a), 32'hF);
    chk("t4_memwrite", 32'(ia.out_memwrite), 32'h1);
    chk("t4_pcsrc", 32'(ia.out_pcsrc), 32'h0);

    // 5: flush drops pending output and the same-cycle op
    flush = 1'b1;
    in_valid = 1'b1; in_cond = 4'hE; in_flagw = 2'b11; in_alu = 4'b0000;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("t5_valid", 32'(ia.out_valid), 32'h0);
    chk("t5_flags", 32'(flags_a), 32'hF);
    chk("t5_exec_a", 32'(exec_a), 32'h4);
    chk("t5_skip_a", 32'(skip_a), 32'h1);
    chk("t5_exec_b", 32'(exec_b), 32'h4);

    // 6: 4-bit counter saturates; cond F differs between configurations
    repeat (12) send(4'hE, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("t6_exec_b_sat", 32'(exec_b), 32'hF);
    chk("t6_exec_a", 32'(exec_a), 32'h10);
    send(4'hE, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("t6_exec_b_hold", 32'(exec_b), 32'hF);
    send(4'hF, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0);
    chk("t6_f_condex_a", 32'(ia.out_condex), 32'h1);
    chk("t6_f_condex_b", 32'(ib.out_condex), 32'h0);
    chk("t6_f_regw_b", 32'(ib.out_regwrite), 32'h0);
    chk("t6_skip_b", 32'(skip_b), 32'h2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 299) == 0);
      flush      = ($urandom_range(0, 15) == 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      in_valid   = ($urandom_range(0, 3) != 0);
      in_cond    = 4'($urandom_range(0, 15));
      in_flagw   = 2'($urandom_range(0, 3));
      in_alu     = 4'($urandom_range(0, 15));
      in_pcs     = 1'($urandom_range(0, 1));
      in_regw    = 1'($urandom_range(0, 1));
      in_memw    = 1'($urandom_range(0, 1));
      in_nowrite = ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
